pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the fetch stage. It holds the current fetch address and advances it by a fixed step each cycle. It supports stall, branch/jump redirect, trap vectoring, and call/return prediction through a small circular return-address stack (RAS). It drives the instruction-memory address and the next-PC path into decode.

## Interface

Parameters:
- XLEN, 32: address width.
- STEP, 4: sequential increment in bytes; power of two, ≥1.
- RESET_VECTOR, 0: PC value after reset.
- TRAP_VECTOR, 32'h100: PC loaded on trap; truncated to XLEN.
- RAS_DEPTH, 4: return-stack entries; power of two, ≥2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC; blocks all actions except trap.
- redirect_en  in  1  load redirect_target.
- redirect_target  in  XLEN  branch/jump target, or fallback return target.
- call_en  in  1  with redirect_en: push return address; ignored alone.
- ret_en  in  1  pop RAS and jump to the popped address.
- trap_en  in  1  jump to TRAP_VECTOR.
- pc  out  XLEN  registered current fetch address.
- pc_plus  out  XLEN  combinational pc+STEP, mod 2^XLEN.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_empty / ras_full  out  1  combinational from ras_count.
- misaligned  out  1  registered; one-cycle pulse.
- ret_underflow  out  1  registered; one-cycle pulse.

## Operation

- Action priority, evaluated each rising edge (highest first):
  1. trap_en: pc <= TRAP_VECTOR. RAS unchanged. Overrides stall.
  2. stall: pc, RAS and flags hold. Flags hold 0 because they are pulses.
  3. redirect_en: pc <= aligned(redirect_target).
     - If call_en is also high: push pc_plus.
     - ret_en is ignored (no pop).
  4. ret_en:
     - RAS non-empty: pop, pc <= popped entry.
     - RAS empty: pc <= aligned(redirect_target), ret_underflow <= 1, count stays 0.
  5. Otherwise: pc <= pc_plus.
- aligned(x) clears the low $clog2(STEP) bits of x.
  - misaligned <= 1 on any taken redirect or underflow-fallback whose dropped bits are non-zero.
  - When STEP=1 there are no dropped bits and misaligned stays 0.
- Arithmetic: pc_plus wraps modulo 2^XLEN, so pc = 2^XLEN − STEP steps to 0. No flag is raised on wrap.
- RAS organisation: circular buffer with a top pointer and a saturating count.
  - Push when not full: write entry, top+1, count+1.
  - Push when full: overwrite the oldest entry, top+1, count stays RAS_DEPTH.
  - Pop: read entry at top, top−1, count−1.
  - Pushed values are pc_plus of the calling cycle.
- misaligned and ret_underflow deassert on the next edge unless the condition occurs again.

## Timing

- Asynchronous reset (reset=0), effective immediately:
  - pc = RESET_VECTOR
  - RAS count = 0, top pointer = 0
  - misaligned = 0, ret_underflow = 0
- RAS entry contents are don't-care after reset.
- After reset deasserts, pc stays RESET_VECTOR until the first rising edge. That edge applies normal priority.
- Reset asserted mid-operation: all state returns to the reset values at once, including pending pulses.
- Latency: every action is visible on pc one cycle after its controls are sampled. pc_plus and the ras_* status outputs follow combinationally.
- Controls are level-sampled at each rising edge. There is no handshake.

## Test plan

- Reset and sequential run: release reset with RESET_VECTOR=0 and hold controls low for 4 edges -> pc = 0, 4, 8, 12, 16. Assert reset mid-run -> pc = 0 immediately, ras_count = 0.
- Stall vs trap: at pc=0x20, assert stall for 3 cycles -> pc stays 0x20. Assert stall and trap_en together -> pc = 0x100 next cycle.
- Call/return: at pc=0x40, assert redirect_en+call_en with target 0x200 -> pc = 0x200, ras_count = 1. Run 2 cycles, then assert ret_en -> pc = 0x44, ras_count = 0.
- RAS overflow (RAS_DEPTH=4): perform 5 calls from pcs 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_full = 1 and ras_count stays 4. Then 4 returns -> pc = 0x54, 0x44, 0x34, 0x24 in order.
- Underflow and misalignment: with the RAS empty, assert ret_en with redirect_target 0x303 -> pc = 0x300, and ret_underflow and misaligned each pulse for exactly one cycle.
- Wrap and priority: pc = 0xFFFF_FFFC with no controls -> pc = 0. Assert redirect_en and ret_en together with one RAS entry -> pc = redirect_target and ras_count unchanged.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch-stage program counter with trap vectoring, branch/jump redirect and
// a small circular return-address stack for call/return prediction.
module pc_unit #(
    parameter int               XLEN         = 32,
    parameter int               STEP         = 4,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(32'h100),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         redirect_en,
    input  logic [XLEN-1:0]              redirect_target,
    input  logic                         call_en,
    input  logic                         ret_en,
    input  logic                         trap_en,
    output logic [XLEN-1:0]              pc,
    output logic [XLEN-1:0]              pc_plus,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         misaligned,
    output logic                         ret_underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    // Bits of an address that alignment to STEP drops (zero when STEP=1).
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(STEP - 1);
    localparam logic [XLEN-1:0] STEP_INC = XLEN'(STEP);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_reg;
    logic [PW-1:0]   top_reg;
    logic [CW-1:0]   count_reg;
    logic            misaligned_reg;
    logic            ret_underflow_reg;

    // Return-address storage; contents are meaningless until pushed.
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];

    logic [XLEN-1:0] aligned_target;
    logic            target_dropped;
    logic            full_now;
    logic            empty_now;
    logic            do_push;
    logic [PW-1:0]   wr_ptr;

    assign pc_plus        = pc_reg + STEP_INC;
    assign aligned_target = redirect_target & ~LOW_MASK;
    assign target_dropped = |(redirect_target & LOW_MASK);
    assign full_now       = (count_reg == CNT_MAX);
    assign empty_now      = (count_reg == '0);

    // top_reg always names the most recent entry, so a push lands one slot
    // above it; on overflow that slot holds the oldest entry and is reused.
    assign wr_ptr  = top_reg + PW'(1);
    assign do_push = !trap_en && !stall && redirect_en && call_en;

    assign pc            = pc_reg;
    assign ras_count     = count_reg;
    assign ras_empty     = empty_now;
    assign ras_full      = full_now;
    assign misaligned    = misaligned_reg;
    assign ret_underflow = ret_underflow_reg;

    // Return-address writes: no reset needed since count gates validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[wr_ptr] <= pc_plus;
        end
    end

    // PC, stack pointer/count and status pulses, in action-priority order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg            <= RESET_VECTOR;
            top_reg           <= '0;
            count_reg         <= '0;
            misaligned_reg    <= 1'b0;
            ret_underflow_reg <= 1'b0;
        end else begin
            // Pulses drop by default and are only re-raised by their cause.
            misaligned_reg    <= 1'b0;
            ret_underflow_reg <= 1'b0;
            if (trap_en) begin
                pc_reg <= TRAP_VECTOR;
            end else if (stall) begin
                pc_reg <= pc_reg;
            end else if (redirect_en) begin
                pc_reg         <= aligned_target;
                misaligned_reg <= target_dropped;
                if (call_en) begin
                    top_reg <= wr_ptr;
                    if (!full_now) begin
                        count_reg <= count_reg + CW'(1);
                    end
                end
            end else if (ret_en) begin
                if (!empty_now) begin
                    pc_reg    <= ras_mem[top_reg];
                    top_reg   <= top_reg - PW'(1);
                    count_reg <= count_reg - CW'(1);
                end else begin
                    // Nothing predicted: fall back to the supplied target.
                    pc_reg            <= aligned_target;
                    misaligned_reg    <= target_dropped;
                    ret_underflow_reg <= 1'b1;
                end
            end else begin
                pc_reg <= pc_plus;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random
// control traffic, all compared against a queue-based reference model.
module tb_pc_unit;

    localparam int STEP  = 4;
    localparam int DEPTH = 4;
    localparam logic [31:0] TV = 32'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        call_en = 1'b0;
    logic        ret_en = 1'b0;
    logic        trap_en = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        misaligned;
    logic        ret_underflow;

    pc_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target),
        .call_en         (call_en),
        .ret_en          (ret_en),
        .trap_en         (trap_en),
        .pc              (pc),
        .pc_plus         (pc_plus),
        .ras_count       (ras_count),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full),
        .misaligned      (misaligned),
        .ret_underflow   (ret_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: PC value, return stack as a queue (back = newest).
    logic [31:0] m_pc = '0;
    logic [31:0] m_ras[$];
    logic        m_mis = 1'b0;
    logic        m_und = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},        pc,                     m_pc);
        check({tag, ".pc_plus"},   pc_plus,                m_pc + STEP);
        check({tag, ".count"},     32'(ras_count),         32'(m_ras.size()));
        check({tag, ".empty"},     32'(ras_empty),         32'(m_ras.size() == 0));
        check({tag, ".full"},      32'(ras_full),          32'(m_ras.size() == DEPTH));
        check({tag, ".misalign"},  32'(misaligned),        32'(m_mis));
        check({tag, ".underflow"}, 32'(ret_underflow),     32'(m_und));
    endtask

    // Apply one cycle of controls, advance the model by the priority rules,
    // then compare just after the edge.
    task automatic step(input string tag, input bit st, input bit rd, input bit ca,
                        input bit re, input bit tr, input logic [31:0] tgt);
        logic [31:0] fallback;
        stall = st; redirect_en = rd; call_en = ca; ret_en = re; trap_en = tr;
        redirect_target = tgt;
        fallback = tgt - (tgt % STEP);
        m_mis = 1'b0;
        m_und = 1'b0;
        if (tr) begin
            m_pc = TV;
        end else if (st) begin
            m_pc = m_pc;
        end else if (rd) begin
            if (ca) begin
                m_ras.push_back(m_pc + STEP);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            m_pc  = fallback;
            m_mis = (tgt % STEP) != 0;
        end else if (re) begin
            if (m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc  = fallback;
                m_und = 1'b1;
                m_mis = (tgt % STEP) != 0;
            end
        end else begin
            m_pc = m_pc + STEP;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        // Reset held from time zero.
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_reset_hold", pc, 32'h0);

        // Sequential run from RESET_VECTOR.
        for (int i = 1; i <= 4; i++) begin
            idle("seq");
            check("seq_val", pc, 32'(4 * i));
        end

        // Put an entry on the stack, then reset mid-cycle.
        step("call_pre_rst", 0, 1, 1, 0, 0, 32'h80);
        #3;
        reset = 1'b0;
        #1;
        m_pc = '0; m_ras.delete(); m_mis = 0; m_und = 0;
        check_all("mid_reset");
        check("mid_reset_cnt", 32'(ras_count), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Stall holds, trap overrides stall.
        step("to20", 0, 1, 0, 0, 0, 32'h20);
        for (int i = 0; i < 3; i++) begin
            step("stall", 1, 0, 0, 0, 0, 32'h0);
            check("stall_val", pc, 32'h20);
        end
        step("stall_trap", 1, 0, 0, 0, 1, 32'h0);
        check("trap_val", pc, 32'h100);

        // Call then return.
        step("to40", 0, 1, 0, 0, 0, 32'h40);
        step("call200", 0, 1, 1, 0, 0, 32'h200);
        check("call_cnt", 32'(ras_count), 32'h1);
        idle("body");
        idle("body");
        step("ret", 0, 0, 0, 1, 0, 32'h0);
        check("ret_val", pc, 32'h44);

        // Five calls into a four-entry stack, then four returns.
        step("to10", 0, 1, 0, 0, 0, 32'h10);
        for (int i = 2; i <= 5; i++) step("ovf_call", 0, 1, 1, 0, 0, 32'(i * 16));
        step("ovf_call5", 0, 1, 1, 0, 0, 32'h600);
        check("ovf_full", 32'(ras_full), 32'h1);
        step("ovf_ret", 0, 0, 0, 1, 0, 32'h0);
        check("ovf_ret1", pc, 32'h54);
        step("ovf_ret", 0, 0, 0, 1, 0, 32'h0);
        check("ovf_ret2", pc, 32'h44);
        step("ovf_ret", 0, 0, 0, 1, 0, 32'h0);
        check("ovf_ret3", pc, 32'h34);
        step("ovf_ret", 0, 0, 0, 1, 0, 32'h0);
        check("ovf_ret4", pc, 32'h24);

        // Underflow fallback with a misaligned target.
        step("undf", 0, 0, 0, 1, 0, 32'h303);
        check("undf_pc", pc, 32'h300);
        check("undf_pulse", 32'({ret_underflow, misaligned}), 32'h3);
        idle("undf_after");
        check("undf_clear", 32'({ret_underflow, misaligned}), 32'h0);

        // Wraparound, then redirect beats ret.
        step("toFFC", 0, 1, 0, 0, 0, 32'hFFFF_FFFC);
        idle("wrap");
        check("wrap_val", pc, 32'h0);
        step("call500", 0, 1, 1, 0, 0, 32'h500);
        step("rd_ret", 0, 1, 0, 1, 0, 32'h700);
        check("rd_ret_pc", pc, 32'h700);
        check("rd_ret_cnt", 32'(ras_count), 32'h1);

        // Random control traffic.
        for (int i = 0; i < 400; i++) begin
            bit st, rd, ca, re, tr;
            st = ($urandom_range(0, 99) < 10);
            tr = ($urandom_range(0, 99) < 3);
            rd = ($urandom_range(0, 99) < 25);
            ca = $urandom_range(0, 1) != 0;
            re = ($urandom_range(0, 99) < 25);
            step("rand", st, rd, ca, re, tr, $urandom & 32'h0000_0FFF);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
